// File: rtl/exec_core_pkg.sv
// ---------------------------------------------------------------------------
// exec_core_pkg
// Shared definitions for the exec_core slice: instruction format codes, ALU
// select codes, cmp result codes, FSM state encoding, instruction field bit
// positions and a decode helper that splits a 16-bit instruction into fields.
// ---------------------------------------------------------------------------
package exec_core_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_IDX_W = 3;

  // Instruction field bit positions
  localparam int unsigned FMT_LSB  = 0;
  localparam int unsigned FMT_MSB  = 1;
  localparam int unsigned SEL_LSB  = 2;
  localparam int unsigned SEL_MSB  = 4;
  localparam int unsigned IMM_LSB  = 5;
  localparam int unsigned IMM_MSB  = 12;
  localparam int unsigned RY_LSB   = 10;
  localparam int unsigned RY_MSB   = 12;
  localparam int unsigned RX_LSB   = 13;
  localparam int unsigned RX_MSB   = 15;
  localparam int unsigned MEM_RSVD_BIT = 2;  // memory format: 0 = load, 1 = reserved

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_BR  = 2'b10,
    FMT_MEM = 2'b11
  } fmt_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_CMP = 3'd7
  } alu_sel_e;

  localparam logic [DATA_W-1:0] CMP_EQ = 16'd0;
  localparam logic [DATA_W-1:0] CMP_GT = 16'd1;
  localparam logic [DATA_W-1:0] CMP_LT = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    fmt_e                  fmt;
    logic [REG_IDX_W-1:0]  rx;
    logic [REG_IDX_W-1:0]  ry;
    alu_sel_e              alu_sel;
    logic [DATA_W-1:0]     imm;      // imm8 zero-extended
    logic                  is_load;
    logic                  is_alu;   // R-type or I-type
  } decoded_t;

  function automatic decoded_t decode(input logic [DATA_W-1:0] ir);
    decoded_t d;
    d.fmt     = fmt_e'(ir[FMT_MSB:FMT_LSB]);
    d.rx      = ir[RX_MSB:RX_LSB];
    d.ry      = ir[RY_MSB:RY_LSB];
    d.alu_sel = alu_sel_e'(ir[SEL_MSB:SEL_LSB]);
    d.imm     = {8'h00, ir[IMM_MSB:IMM_LSB]};
    d.is_load = (d.fmt == FMT_MEM) && !ir[MEM_RSVD_BIT];
    d.is_alu  = (d.fmt == FMT_R) || (d.fmt == FMT_I);
    return d;
  endfunction

endpackage

// File: rtl/exec_core_alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 16-bit ALU. All results wrap mod 2^16.
// Ports:
//   a       - A operand (R[rx])
//   b       - B operand (R[ry] or zero-extended immediate)
//   alu_sel - operation select
//   result  - operation result
// ---------------------------------------------------------------------------
module alu
  import exec_core_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_sel_e          alu_sel,
  output logic [DATA_W-1:0] result
);

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    result = '0;
    unique case (alu_sel)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = a << b[3:0];
      ALU_SHR: result = a >> b[3:0];
      ALU_CMP: begin
        if (a == b)     result = CMP_EQ;
        else if (a > b) result = CMP_GT;
        else            result = CMP_LT;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_core.sv
// ---------------------------------------------------------------------------
// exec_core
// Multi-cycle execution core: IDLE -> EXEC/MEM -> WB -> IDLE.
// Ports:
//   clk             - system clock
//   reset           - asynchronous, active-high reset
//   run_core        - instr holds a valid instruction
//   instr           - instruction (en_memory_inst=0) or load data (=1)
//   done            - one-cycle pulse at retirement (WB)
//   en_memory_inst  - high only in MEM; fetch side returns load data
//   memory_addr     - load address R[ry] in MEM, else 0
//   last_alu_result - most recent R/I-type write-back value
//   dbg_rx_out      - value written to Rx in the current WB cycle, else 0
// ---------------------------------------------------------------------------
module exec_core
  import exec_core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run_core,
  input  logic [DATA_W-1:0] instr,
  output logic              done,
  output logic              en_memory_inst,
  output logic [DATA_W-1:0] memory_addr,
  output logic [DATA_W-1:0] last_alu_result,
  output logic [DATA_W-1:0] dbg_rx_out
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [DATA_W-1:0] last_q;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  decoded_t          dec;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] rf_ry;
  logic [DATA_W-1:0] alu_result;
  logic              wb_write;

  assign dec   = decode(ir_q);
  // Operands are read in EXEC/MEM while the file still holds pre-write values,
  // so rx == ry naturally sees the old value on both sides.
  assign op_a  = rf_q[dec.rx];
  assign rf_ry = rf_q[dec.ry];
  assign op_b  = (dec.fmt == FMT_I) ? dec.imm : rf_ry;

  alu u_alu (
    .a       (op_a),
    .b       (op_b),
    .alu_sel (dec.alu_sel),
    .result  (alu_result)
  );

  // Branches and reserved memory ops retire through WB without writing.
  assign wb_write = (state_q == ST_WB) && (dec.is_alu || dec.is_load);

  // ---------------- next-state / datapath ----------------
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    c_d     = c_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_core) begin
          ir_d    = instr;
          state_d = decode(instr).is_load ? ST_MEM : ST_EXEC;
        end
      end
      ST_EXEC: begin
        c_d     = alu_result;
        state_d = ST_WB;
      end
      ST_MEM: begin
        c_d     = instr;  // load data returned on the instr bus
        state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
    end
  end

  // NOTE: the register file is small and must read as zero after reset, so it
  // is reset like ordinary flops rather than inferred as an unreset RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_write) begin
      rf_q[dec.rx] <= c_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
    end else if ((state_q == ST_WB) && dec.is_alu) begin
      last_q <= c_q;
    end
  end

  // ---------------- outputs (decoded from state, cleared by reset) ----------
  assign done            = (state_q == ST_WB);
  assign en_memory_inst  = (state_q == ST_MEM);
  assign memory_addr     = en_memory_inst ? rf_ry : '0;
  assign last_alu_result = last_q;
  assign dbg_rx_out      = wb_write ? c_q : '0;

endmodule

// File: tb/tb_exec_core.sv
// ---------------------------------------------------------------------------
// tb_exec_core
// Directed self-checking bench for exec_core. A small memory model answers
// load requests on the instr bus while en_memory_inst is high.
// ---------------------------------------------------------------------------
module tb_exec_core;

  logic        clk;
  logic        reset;
  logic        run_core;
  logic [15:0] instr;
  logic [15:0] fetch_instr;
  logic        done;
  logic        en_memory_inst;
  logic [15:0] memory_addr;
  logic [15:0] last_alu_result;
  logic [15:0] dbg_rx_out;

  int tests_run    = 0;
  int tests_failed = 0;

  // ALU select codes
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                         OP_OR  = 3'd3, OP_XOR = 3'd4, OP_SHL = 3'd5,
                         OP_SHR = 3'd6, OP_CMP = 3'd7;

  function automatic logic [15:0] mem_read(input logic [15:0] addr);
    if (addr == 16'h0010) return 16'hBEEF;
    return addr ^ 16'h5A5A;
  endfunction

  assign instr = en_memory_inst ? mem_read(memory_addr) : fetch_instr;

  exec_core dut (
    .clk             (clk),
    .reset           (reset),
    .run_core        (run_core),
    .instr           (instr),
    .done            (done),
    .en_memory_inst  (en_memory_inst),
    .memory_addr     (memory_addr),
    .last_alu_result (last_alu_result),
    .dbg_rx_out      (dbg_rx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] r_op(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] op);
    return {rx, ry, 5'b0, op, 2'b00};
  endfunction

  function automatic logic [15:0] i_op(input logic [2:0] rx, input logic [2:0] op, input logic [7:0] imm);
    return {rx, imm, op, 2'b01};
  endfunction

  function automatic logic [15:0] ld_op(input logic [2:0] rx, input logic [2:0] ry);
    return {rx, ry, 7'b0, 1'b0, 2'b11};
  endfunction

  // Issue one instruction from IDLE and watch four cycles. Cycle 0 is the
  // capture cycle, so retirement is expected in cycle 2.
  task automatic run_instr(input logic [15:0] ins, output int done_at, output int done_cnt,
                           output int mem_cnt, output logic [15:0] mem_addr_seen,
                           output logic [15:0] dbg_seen);
    done_at = 0; done_cnt = 0; mem_cnt = 0; mem_addr_seen = 16'hxxxx; dbg_seen = 16'hxxxx;
    fetch_instr = ins;
    run_core    = 1'b1;
    @(posedge clk);
    #1 run_core = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (done) begin
        if (done_cnt == 0) done_at = c;
        done_cnt++;
        dbg_seen = dbg_rx_out;
      end
      if (en_memory_inst) begin
        mem_cnt++;
        mem_addr_seen = memory_addr;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] ins,
                       input logic [15:0] exp_last, input logic [15:0] exp_dbg);
    int da, dc, mc;
    logic [15:0] ma, dbg;
    run_instr(ins, da, dc, mc, ma, dbg);
    check({tag, "_done_at"}, 16'(da), 16'd2);
    check({tag, "_done_cnt"}, 16'(dc), 16'd1);
    check({tag, "_last"}, last_alu_result, exp_last);
    check({tag, "_dbg"}, dbg, exp_dbg);
  endtask

  // Read a register through I-type add #0; result lands in last_alu_result.
  task automatic read_reg(input string tag, input logic [2:0] r, input logic [15:0] exp);
    int da, dc, mc;
    logic [15:0] ma, dbg;
    run_instr(i_op(r, OP_ADD, 8'd0), da, dc, mc, ma, dbg);
    check(tag, last_alu_result, exp);
  endtask

  initial begin
    int da, dc, mc;
    logic [15:0] ma, dbg;
    logic [15:0] done_mask;

    reset       = 1'b1;
    run_core    = 1'b0;
    fetch_instr = 16'h0000;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_done", {15'b0, done}, 16'd0);
    check("rst_en_mem", {15'b0, en_memory_inst}, 16'd0);
    check("rst_mem_addr", memory_addr, 16'h0000);
    check("rst_last", last_alu_result, 16'h0000);
    check("rst_dbg", dbg_rx_out, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_done", {15'b0, done}, 16'd0);

    // ---- R-type sub: R1=5, R2=3 -> R1=2 ----
    do_op("ld_r1", i_op(3'd1, OP_ADD, 8'd5), 16'h0005, 16'h0005);
    do_op("ld_r2", i_op(3'd2, OP_ADD, 8'd3), 16'h0003, 16'h0003);
    do_op("sub_r1_r2", r_op(3'd1, 3'd2, OP_SUB), 16'h0002, 16'h0002);

    // ---- I-type wrap: R3 = 0 - 16 = FFF0, then + 255 = 00EF ----
    do_op("r3_fff0", i_op(3'd3, OP_SUB, 8'd16), 16'hFFF0, 16'hFFF0);
    do_op("add_wrap", i_op(3'd3, OP_ADD, 8'd255), 16'h00EF, 16'h00EF);

    // ---- load R4 <- mem[R5=0x10] ----
    do_op("ld_r5", i_op(3'd5, OP_ADD, 8'h10), 16'h0010, 16'h0010);
    run_instr(ld_op(3'd4, 3'd5), da, dc, mc, ma, dbg);
    check("load_done_at", 16'(da), 16'd2);
    check("load_done_cnt", 16'(dc), 16'd1);
    check("load_mem_cycles", 16'(mc), 16'd1);
    check("load_mem_addr", ma, 16'h0010);
    check("load_dbg", dbg, 16'hBEEF);
    check("load_last_held", last_alu_result, 16'h0010);
    check("load_idle_addr", memory_addr, 16'h0000);
    read_reg("load_r4", 3'd4, 16'hBEEF);

    // ---- cmp: 7 vs 9 -> 2; 9 vs 2 -> 1; equal (rx==ry) -> 0 ----
    do_op("clr_r1", i_op(3'd1, OP_AND, 8'd0), 16'h0000, 16'h0000);
    do_op("set_r1", i_op(3'd1, OP_ADD, 8'd7), 16'h0007, 16'h0007);
    do_op("clr_r2", i_op(3'd2, OP_AND, 8'd0), 16'h0000, 16'h0000);
    do_op("set_r2", i_op(3'd2, OP_ADD, 8'd9), 16'h0009, 16'h0009);
    do_op("cmp_lt", r_op(3'd1, 3'd2, OP_CMP), 16'h0002, 16'h0002);
    do_op("cmp_gt", r_op(3'd2, 3'd1, OP_CMP), 16'h0001, 16'h0001);
    do_op("cmp_eq", r_op(3'd1, 3'd1, OP_CMP), 16'h0000, 16'h0000);

    // ---- fetch-side NOP 0x0000 ----
    do_op("nop", 16'h0000, 16'h0000, 16'h0000);
    read_reg("nop_r0", 3'd0, 16'h0000);

    // ---- logic and shift ops ----
    do_op("or_imm", i_op(3'd6, OP_OR, 8'hA5), 16'h00A5, 16'h00A5);
    do_op("shl_4", i_op(3'd6, OP_SHL, 8'h04), 16'h0A50, 16'h0A50);
    do_op("shr_3", i_op(3'd6, OP_SHR, 8'h13), 16'h014A, 16'h014A);
    do_op("xor_ff", i_op(3'd6, OP_XOR, 8'hFF), 16'h01B5, 16'h01B5);
    do_op("add_rr", r_op(3'd6, 3'd5, OP_ADD), 16'h01C5, 16'h01C5);

    // ---- branch and reserved memory op write nothing ----
    do_op("branch", 16'hFFFE, 16'h01C5, 16'h0000);
    do_op("mem_rsvd", {3'd6, 3'd5, 7'b0, 1'b1, 2'b11}, 16'h01C5, 16'h0000);
    read_reg("rsvd_r6", 3'd6, 16'h01C5);

    // ---- back-to-back: run_core held high across three adds ----
    done_mask   = '0;
    fetch_instr = i_op(3'd7, OP_ADD, 8'd1);
    run_core    = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_mask[c] = 1'b1;
      if (c == 1) fetch_instr = i_op(3'd7, OP_ADD, 8'd2);
      if (c == 4) fetch_instr = r_op(3'd7, 3'd7, OP_ADD);
      if (c == 7) run_core = 1'b0;
    end
    check("b2b_done_cycles", done_mask, 16'h0124);
    check("b2b_last", last_alu_result, 16'h0006);
    repeat (2) @(negedge clk);

    // ---- reset during MEM ----
    fetch_instr = ld_op(3'd4, 3'd5);
    run_core    = 1'b1;
    @(posedge clk);
    #1 run_core = 1'b0;
    @(negedge clk);
    check("mem_en_before_rst", {15'b0, en_memory_inst}, 16'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_en_mem", {15'b0, en_memory_inst}, 16'd0);
    check("mid_rst_mem_addr", memory_addr, 16'h0000);
    check("mid_rst_done", {15'b0, done}, 16'd0);
    check("mid_rst_last", last_alu_result, 16'h0000);
    done_mask = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) done_mask[c] = 1'b1;
    end
    check("mid_rst_no_done", done_mask, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    read_reg("post_rst_r4", 3'd4, 16'h0000);
    read_reg("post_rst_r5", 3'd5, 16'h0000);
    read_reg("post_rst_r7", 3'd7, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exec_core.md
EXEC_CORE -- requirements
Module: exec_core

Interface
REQ-001 SHALL have ports clk input 1 (system clock) and reset input 1 (one clock; reset asynchronous, active-high), listed first.
REQ-002 SHALL have run_core input 1: fetch side signals the instr bus holds a valid instruction.
REQ-003 SHALL have instr input 16: fetched instruction when en_memory_inst=0; load data when en_memory_inst=1.
REQ-004 SHALL have done output 1: one-cycle pulse at instruction retirement.
REQ-005 SHALL have en_memory_inst output 1: steers the fetch-side memory address to memory_addr.
REQ-006 SHALL have memory_addr output 16: load address.
REQ-007 SHALL have last_alu_result output 16: most recent ALU write-back value; feeds branch condition evaluation.
REQ-008 SHALL have dbg_rx_out output 16: value written to Rx in the current WB cycle, else 0.

Function
REQ-009 SHALL decode instr[1:0]: 00 R-type, 01 I-type, 10 branch, 11 memory.
REQ-010 SHALL decode R-type fields: rx=[15:13], ry=[12:10], alu_sel=[4:2]; B operand = R[ry].
REQ-011 SHALL decode I-type fields: rx=[15:13], imm8=[12:5] zero-extended to 16, alu_sel=[4:2]; B operand = imm.
REQ-012 SHALL decode memory fields: rx=[15:13], ry=[12:10], [2]=0 load; [2]=1 reserved, retired as NOP.
REQ-013 SHALL implement ALU ops, all results mod 2^16: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl by B[3:0], 6 shr logical by B[3:0], 7 cmp (0 if A==B, 1 if A>B unsigned, 2 if A<B).
REQ-014 SHALL hold an 8 x 16 register file; A operand = R[rx]; writes only in WB.
REQ-015 SHALL implement FSM states IDLE, EXEC, MEM, WB.
REQ-016 IDLE with run_core=1 SHALL latch instr into IR; next state MEM if load, else EXEC.
REQ-017 IDLE with run_core=0 SHALL hold IDLE; done=0.
REQ-018 EXEC SHALL compute the ALU result into result register C; next state WB.
REQ-019 MEM SHALL drive en_memory_inst=1 and memory_addr=R[ry], capture instr into C at the cycle end, then go to WB.
REQ-020 en_memory_inst SHALL be 1 only in MEM; memory_addr SHALL be 0 outside MEM.
REQ-021 WB SHALL pulse done=1 for exactly one cycle and return to IDLE.
REQ-022 WB for ALU ops and load SHALL write R[rx]<=C; branch, reserved and NOP SHALL write nothing.
REQ-023 last_alu_result SHALL update to C in WB of R/I-type instructions only; loads, branches and NOPs hold it.
REQ-024 Latency from IR capture: R/I/branch/NOP done at capture+2 cycles; load done at capture+2 cycles via MEM.
REQ-025 If run_core is still 1 in the IDLE cycle after WB, the next instruction SHALL be captured with no bubble beyond IDLE.
REQ-026 instr=16'h0000 (R-type add R0,R0) SHALL execute normally; it is the fetch-side NOP and leaves R0 unchanged.
REQ-027 rx==ry SHALL use the pre-write value of the register as both operands.

Reset
REQ-028 Assertion of reset SHALL asynchronously force state=IDLE, IR=0, C=0, all R[i]=0, last_alu_result=0, done=0, en_memory_inst=0, memory_addr=0, dbg_rx_out=0.
REQ-029 Reset mid-instruction (EXEC/MEM/WB) SHALL abort with no register write and no done pulse.
REQ-030 After reset release, the first capture SHALL occur at the first rising edge with run_core=1.

Structure
REQ-031 A shared package SHALL hold the format codes, ALU select codes, cmp result codes, FSM state encoding and field bit positions.
REQ-032 The ALU SHALL be a combinational sub-module named alu (a, b, alu_sel -> result); all sequencing stays in exec_core.

Verification
REQ-033 Reset, then R1 holds 5, R2 holds 3, R-type sub R1,R2 -> done at capture+2, R1=2, last_alu_result=2.
REQ-034 I-type add R3 imm 255 with R3=16'hFFF0 -> R3=16'h00EF (wrap), done pulse exactly 1 cycle.
REQ-035 Load R4 from addr R5=16'h0010, memory[0x10]=16'hBEEF -> en_memory_inst=1 for one cycle with memory_addr=16'h0010, R4=16'hBEEF, last_alu_result unchanged.
REQ-036 cmp R1,R2 with 7 vs 9 -> R1=2, last_alu_result=2; equal values -> 0.
REQ-037 run_core held high across three back-to-back add instructions -> done pulses at cycles 2, 5 and 8 after the first capture.
REQ-038 Reset asserted during MEM -> en_memory_inst drops immediately, no done, all registers read 0.
